// File: rtl/mm_refill_arbiter.sv
// Round-robin refill arbiter between the I-cache and D-cache for the shared main-memory read port.
// Optional perf counters are enabled by defining MM_REFILL_PERF_EN.
`timescale 1ns/1ps
module mm_refill_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    output logic        I_Grant,
    input  logic        D_Req,
    input  logic [31:0] D_Addr,
    output logic        D_Grant,
    output logic [31:0] Mem_Addr,
    output logic        Access_MM,
    input  logic [31:0] Data_MM,
    output logic [31:0] Rsp_Data,
    output logic        Rsp_Valid,
    output logic        Rsp_Last,
    output logic        Rsp_Id,
    output logic        Busy
`ifdef MM_REFILL_PERF_EN
    ,
    output logic [15:0] I_Refill_Cnt,
    output logic [15:0] D_Refill_Cnt,
    output logic [31:0] Stall_Cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_e;

    localparam logic [31:0] BLK_MASK  = 32'(BLOCK_WORDS * 4 - 1);
    localparam logic [4:0]  LAST_WORD = 5'(BLOCK_WORDS - 1);
    localparam logic [3:0]  LAT_INIT  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [4:0]  word_q, word_d;
    logic        owner_q, owner_d;
    logic        last_srv_q, last_srv_d;   // 1 = D served last
    logic [31:0] base_q, base_d;
    logic        i_grant_q, i_grant_d;
    logic        d_grant_q, d_grant_d;
    logic        acc_q, acc_d;
    logic [31:0] maddr_q, maddr_d;
    logic        acc_last_q, acc_last_d;
    logic        acc_id_q, acc_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_id_q, rsp_id_d;

    logic i_win, d_win, take;

    assign i_win = I_Req && (!D_Req || last_srv_q);
    assign d_win = D_Req && !i_win;
    assign take  = (state_q == IDLE) && (I_Req || D_Req);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (take) state_d = (LATENCY > 0) ? WAIT : XFER;
            WAIT: if (lat_q == 4'd0) state_d = XFER;
            XFER: if (word_q == LAST_WORD) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/enable are registered from the XFER state; the response is registered from the access.
    always_comb begin
        lat_d      = lat_q;
        word_d     = word_q;
        owner_d    = owner_q;
        last_srv_d = last_srv_q;
        base_d     = base_q;
        i_grant_d  = 1'b0;
        d_grant_d  = 1'b0;
        acc_d      = 1'b0;
        maddr_d    = 32'd0;
        acc_last_d = 1'b0;
        acc_id_d   = 1'b0;
        if (take) begin
            i_grant_d  = i_win;
            d_grant_d  = d_win;
            owner_d    = d_win;
            last_srv_d = d_win;
            base_d     = (d_win ? D_Addr : I_Addr) & ~BLK_MASK;
            word_d     = 5'd0;
            lat_d      = LAT_INIT;
        end
        if (state_q == WAIT) lat_d = lat_q - 4'd1;
        if (state_q == XFER) begin
            acc_d      = 1'b1;
            maddr_d    = base_q | (32'({word_q, 2'b00}) & BLK_MASK);
            acc_last_d = (word_q == LAST_WORD);
            acc_id_d   = owner_q;
            word_d     = word_q + 5'd1;
        end
        rsp_valid_d = acc_q;
        rsp_data_d  = acc_q ? Data_MM : 32'd0;
        rsp_last_d  = acc_q && acc_last_q;
        rsp_id_d    = acc_q && acc_id_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lat_q       <= 4'd0;
            word_q      <= 5'd0;
            owner_q     <= 1'b0;
            last_srv_q  <= 1'b1;
            base_q      <= 32'd0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
            acc_q       <= 1'b0;
            maddr_q     <= 32'd0;
            acc_last_q  <= 1'b0;
            acc_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            lat_q       <= lat_d;
            word_q      <= word_d;
            owner_q     <= owner_d;
            last_srv_q  <= last_srv_d;
            base_q      <= base_d;
            i_grant_q   <= i_grant_d;
            d_grant_q   <= d_grant_d;
            acc_q       <= acc_d;
            maddr_q     <= maddr_d;
            acc_last_q  <= acc_last_d;
            acc_id_q    <= acc_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign I_Grant   = i_grant_q;
    assign D_Grant   = d_grant_q;
    assign Mem_Addr  = maddr_q;
    assign Access_MM = acc_q;
    assign Rsp_Data  = rsp_data_q;
    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Last  = rsp_last_q;
    assign Rsp_Id    = rsp_id_q;
    assign Busy      = (state_q != IDLE);

`ifdef MM_REFILL_PERF_EN
    logic [15:0] i_cnt_q, d_cnt_q;
    logic [31:0] stall_q;
    logic        stall;

    // The grant cycle itself is not a stall: the requester is still holding Req while it sees Grant.
    assign stall = (I_Req && !(take && i_win) && !i_grant_q) ||
                   (D_Req && !(take && d_win) && !d_grant_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            i_cnt_q <= 16'd0;
            d_cnt_q <= 16'd0;
            stall_q <= 32'd0;
        end else begin
            if (i_grant_q && (i_cnt_q != 16'hFFFF)) i_cnt_q <= i_cnt_q + 16'd1;
            if (d_grant_q && (d_cnt_q != 16'hFFFF)) d_cnt_q <= d_cnt_q + 16'd1;
            if (stall && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
        end
    end

    assign I_Refill_Cnt = i_cnt_q;
    assign D_Refill_Cnt = d_cnt_q;
    assign Stall_Cnt    = stall_q;
`endif

endmodule
